// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector generation, exception/ERET flush with redirect PC,
// post-flush refill window and a stall watchdog with a sticky timeout flag.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VEC       = 32'h0000_0020,
  parameter int          REFILL_CYCLES = 2,
  parameter int          CNT_W         = 8,
  parameter int          STALL_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        eret,
  input  logic [31:0] epc_reg,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout
);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         refill_reg, refill_next;
  logic [CNT_W-1:0]   wd_reg, wd_next;
  logic [31:0]        pc_reg, pc_next;
  logic               flush_reg;
  logic               timeout_reg, timeout_next;
  logic [5:0]         req_stall;
  logic [5:0]         stall_int;

  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem)      req_stall = 6'b011111;
    else if (stallreq_ex)  req_stall = 6'b001111;
    else if (stallreq_id)  req_stall = 6'b000111;
    else if (stallreq_if)  req_stall = 6'b000111;
  end

  always_comb begin
    state_next   = state_reg;
    refill_next  = refill_reg;
    pc_next      = pc_reg;
    stall_int    = 6'b000000;
    wd_next      = wd_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      RUN: begin
        if (excp_valid || eret) begin
          state_next = FLUSH;
          pc_next    = excp_valid ? EXC_VEC : epc_reg;
        end else begin
          stall_int = req_stall;
        end
      end
      FLUSH: begin
        refill_next = 4'(REFILL_CYCLES);
        state_next  = REFILL;
      end
      REFILL: begin
        // Redirect requests here come from squashed slots, so only stalls matter.
        stall_int = req_stall;
        if (stall_int == 6'b000000) begin
          refill_next = refill_reg - 4'd1;
          if (refill_reg == 4'd1) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    if (stall_int == 6'b000000) begin
      wd_next = '0;
    end else if (state_reg == RUN) begin
      if (wd_reg != {CNT_W{1'b1}}) wd_next = wd_reg + 1'b1;
      if (wd_reg >= CNT_W'(STALL_TIMEOUT - 1)) timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      refill_reg  <= 4'd0;
      wd_reg      <= '0;
      pc_reg      <= 32'd0;
      flush_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      refill_reg  <= refill_next;
      wd_reg      <= wd_next;
      pc_reg      <= pc_next;
      flush_reg   <= (state_next == FLUSH);
      timeout_reg <= timeout_next;
    end
  end

  // Stall must read as zero for the whole reset interval, not just after the next edge.
  assign stall   = rst ? 6'b000000 : stall_int;
  assign flush   = flush_reg;
  assign new_pc  = pc_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic, compared each
// cycle against a phase/countdown reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam int REFILL = 2;
  localparam int TMO    = 200;
  localparam int WD_MAX = 255;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, eret;
  logic [31:0] epc_reg;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  bit          m_flushing;
  int          m_refill_left;
  int          m_stall_run;
  bit          m_timeout;
  logic [31:0] m_pc;

  pipe_ctrl #(.EXC_VEC(EXC_VEC), .REFILL_CYCLES(REFILL), .CNT_W(8), .STALL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .eret(eret), .epc_reg(epc_reg),
    .stall(stall), .flush(flush), .new_pc(new_pc), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] prio(input logic [3:0] req); // {mem,ex,id,if}
    if (req[3]) return 6'b011111;
    if (req[2]) return 6'b001111;
    if (req[1] || req[0]) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_flushing = 0; m_refill_left = 0; m_stall_run = 0; m_timeout = 0; m_pc = 32'd0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model across the edge.
  task automatic cycle(input string tag, input logic [3:0] req, input logic ex,
                       input logic er, input logic [31:0] epc);
    bit running;
    logic [5:0] es;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excp_valid = ex; eret = er; epc_reg = epc;
    @(negedge clk);
    running = !m_flushing && (m_refill_left == 0);
    es = (m_flushing || (running && (ex || er))) ? 6'b000000 : prio(req);
    chk({tag, "_stall"},   {26'd0, stall}, {26'd0, es});
    chk({tag, "_flush"},   {31'd0, flush}, {31'd0, m_flushing});
    chk({tag, "_new_pc"},  new_pc, m_pc);
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, m_timeout});
    if (es == 6'b000000) m_stall_run = 0;
    else if (running) begin
      if (m_stall_run < WD_MAX) m_stall_run++;
      if (m_stall_run >= TMO) m_timeout = 1;
    end
    if (m_flushing) begin
      m_flushing = 0;
      m_refill_left = REFILL;
    end else if (m_refill_left > 0) begin
      if (es == 6'b000000) m_refill_left--;
    end else if (ex || er) begin
      m_flushing = 1;
      m_pc = ex ? EXC_VEC : epc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 1;
    excp_valid = 1; eret = 0; epc_reg = 32'h0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_stall",   {26'd0, stall}, 32'd0);
    chk("rst_flush",   {31'd0, flush}, 32'd0);
    chk("rst_new_pc",  new_pc, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0; stallreq_mem = 0; excp_valid = 0;

    // 1: ex stall for 3 cycles
    for (int i = 0; i < 3; i++) cycle("t1_ex", 4'b0100, 0, 0, 0);
    cycle("t1_idle", 4'b0000, 0, 0, 0);
    $display("test1 ex-stall done");

    // 2: mem wins over id, then id alone
    cycle("t2_memid", 4'b1010, 0, 0, 0);
    cycle("t2_id",    4'b0010, 0, 0, 0);
    cycle("t2_if",    4'b0001, 0, 0, 0);
    cycle("t2_idle",  4'b0000, 0, 0, 0);
    $display("test2 priority done");

    // 3: exception, ignored exception during refill, then back in RUN
    cycle("t3_exc",   4'b0100, 1, 0, 32'h0000_5555);
    cycle("t3_flush", 4'b1000, 1, 0, 0);
    chk("t3_new_pc_20", new_pc, 32'h20);
    cycle("t3_ref1",  4'b0000, 1, 0, 0);
    cycle("t3_ref2",  4'b0000, 0, 0, 0);
    cycle("t3_run",   4'b0000, 0, 0, 0);
    chk("t3_no_reflush", {31'd0, flush}, 32'd0);
    $display("test3 exception/refill done");

    // 4: eret redirect, then simultaneous excp+eret
    cycle("t4_eret",  4'b0000, 0, 1, 32'h0000_1000);
    chk("t4_eret_pc", new_pc, 32'h1000);
    for (int i = 0; i < 4; i++) cycle("t4_drain", 4'b0000, 0, 0, 0);
    cycle("t4_both",  4'b0000, 1, 1, 32'h0000_1000);
    chk("t4_both_pc", new_pc, 32'h20);
    for (int i = 0; i < 4; i++) cycle("t4_drain2", 4'b0000, 0, 0, 0);
    $display("test4 eret done");

    // 5: watchdog
    for (int i = 0; i < 250; i++) begin
      cycle("t5_mem", 4'b1000, 0, 0, 0);
      if (i == 198) chk("t5_wd_199", {31'd0, timeout}, 32'd0);
      if (i == 199) chk("t5_wd_200", {31'd0, timeout}, 32'd1);
    end
    for (int i = 0; i < 3; i++) cycle("t5_release", 4'b0000, 0, 0, 0);
    chk("t5_sticky", {31'd0, timeout}, 32'd1);
    $display("test5 watchdog done");

    // 6: async reset mid-FLUSH
    cycle("t6_exc", 4'b0000, 1, 0, 0);
    chk("t6_in_flush", {31'd0, flush}, 32'd1);
    stallreq_mem = 1; excp_valid = 1;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_stall",   {26'd0, stall}, 32'd0);
    chk("t6_rst_flush",   {31'd0, flush}, 32'd0);
    chk("t6_rst_new_pc",  new_pc, 32'd0);
    chk("t6_rst_timeout", {31'd0, timeout}, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    cycle("t6_after", 4'b0000, 0, 0, 0);
    cycle("t6_run",   4'b0100, 0, 0, 0);
    cycle("t6_idle",  4'b0000, 0, 0, 0);
    $display("test6 async reset done");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] req;
      req[0] = ($urandom_range(0, 3) == 0);
      req[1] = ($urandom_range(0, 4) == 0);
      req[2] = ($urandom_range(0, 5) == 0);
      req[3] = ($urandom_range(0, 6) == 0);
      cycle("rnd", req, ($urandom_range(0, 12) == 0), ($urandom_range(0, 12) == 0), $urandom);
    end
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
